// File: rtl/vga_plot_arbiter.sv
// N-channel arbiter that grants one drawing source the vga_adapter plot path.
// Optional macro CLIP_EN: out-of-bounds pixels are acked and counted but never plotted.
module vga_plot_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int C_W         = 3,
    parameter int ROUND_ROBIN = 0,
    parameter int MAX_BURST   = 0,
    parameter int X_MAX       = 160,
    parameter int Y_MAX       = 120
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     req,
    input  logic [NUM_CH-1:0]     valid,
    input  logic [NUM_CH*X_W-1:0] x_in,
    input  logic [NUM_CH*Y_W-1:0] y_in,
    input  logic [NUM_CH*C_W-1:0] color_in,
    output logic [NUM_CH-1:0]     grant,
    output logic [NUM_CH-1:0]     ack,
    output logic                  busy,
    output logic [X_W-1:0]        x,
    output logic [Y_W-1:0]        y,
    output logic [C_W-1:0]        color,
    output logic                  plot
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 8;

`ifdef CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    typedef enum logic {IDLE, OWN} state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  burst_q, burst_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [C_W-1:0]    color_q, color_d;
    logic              plot_q, plot_d;

    logic [X_W-1:0]    px_x;
    logic [Y_W-1:0]    px_y;
    logic [C_W-1:0]    px_c;
    logic              accept, clip, at_limit, found;
    logic [IDX_W-1:0]  winner;
    int                cand;

    assign ack    = grant_q & valid;
    assign accept = |ack;

    always_comb begin
        px_x = '0;
        px_y = '0;
        px_c = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (owner_q == IDX_W'(k)) begin
                px_x = x_in[k*X_W +: X_W];
                px_y = y_in[k*Y_W +: Y_W];
                px_c = color_in[k*C_W +: C_W];
            end
        end
    end

    assign clip = CLIP_ON && ((32'(px_x) >= X_MAX) || (32'(px_y) >= Y_MAX));

    // Round-robin scans upward from the slot after the last winner; fixed priority scans from 0.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ROUND_ROBIN != 0) cand = (int'(rr_ptr_q) + 1 + i) % NUM_CH;
            else                  cand = i;
            if (!found && req[IDX_W'(cand)]) begin
                found  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        x_d      = x_q;
        y_d      = y_q;
        color_d  = color_q;
        plot_d   = accept && !clip;
        at_limit = 1'b0;
        if (accept && !clip) begin
            x_d     = px_x;
            y_d     = px_y;
            color_d = px_c;
        end
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d         = OWN;
                    owner_d         = winner;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    rr_ptr_d        = winner;
                end
            end
            OWN: begin
                if (accept && (burst_q != '1)) burst_d = burst_q + 1'b1;
                if ((MAX_BURST > 0) && accept && (32'(burst_q) + 1 >= MAX_BURST)) at_limit = 1'b1;
                // A pixel offered in the release cycle has already been accepted above.
                if (!req[owner_q] || at_limit) begin
                    state_d = IDLE;
                    grant_d = '0;
                    burst_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= IDX_W'(NUM_CH - 1);
            burst_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= '0;
            plot_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
            x_q      <= x_d;
            y_q      <= y_d;
            color_q  <= color_d;
            plot_q   <= plot_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == OWN);
    assign x     = x_q;
    assign y     = y_q;
    assign color = color_q;
    assign plot  = plot_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: a fixed-priority and a round-robin (burst 2) instance share stimulus.
module tb_vga_plot_arbiter;
    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
`ifdef CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic [N-1:0]  req, valid;
    logic [N*XW-1:0] x_in;
    logic [N*YW-1:0] y_in;
    logic [N*CW-1:0] color_in;

    logic [N-1:0]  grant_o [2];
    logic [N-1:0]  ack_o   [2];
    logic          busy_o  [2];
    logic          plot_o  [2];
    logic [XW-1:0] x_o     [2];
    logic [YW-1:0] y_o     [2];
    logic [CW-1:0] c_o     [2];
    logic [N-1:0]  ack_pre [2];

    vga_plot_arbiter #(.NUM_CH(N), .X_W(XW), .Y_W(YW), .C_W(CW), .ROUND_ROBIN(0), .MAX_BURST(0)) u_fp (
        .clock(clock), .reset(reset), .req(req), .valid(valid), .x_in(x_in), .y_in(y_in),
        .color_in(color_in), .grant(grant_o[0]), .ack(ack_o[0]), .busy(busy_o[0]),
        .x(x_o[0]), .y(y_o[0]), .color(c_o[0]), .plot(plot_o[0]));

    vga_plot_arbiter #(.NUM_CH(N), .X_W(XW), .Y_W(YW), .C_W(CW), .ROUND_ROBIN(1), .MAX_BURST(2)) u_rr (
        .clock(clock), .reset(reset), .req(req), .valid(valid), .x_in(x_in), .y_in(y_in),
        .color_in(color_in), .grant(grant_o[1]), .ack(ack_o[1]), .busy(busy_o[1]),
        .x(x_o[1]), .y(y_o[1]), .color(c_o[1]), .plot(plot_o[1]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: owner index (-1 = nobody), last winner, pixels taken this burst.
    typedef struct {
        int owner;
        int last;
        int cnt;
        bit plot;
        int x;
        int y;
        int c;
    } mdl_t;

    mdl_t m [2];
    bit   mdl_ok = 1'b0;

    function automatic int chx(int k); return int'(x_in[k*XW +: XW]); endfunction
    function automatic int chy(int k); return int'(y_in[k*YW +: YW]); endfunction
    function automatic int chc(int k); return int'(color_in[k*CW +: CW]); endfunction
    function automatic int max_burst(int d); return (d == 1) ? 2 : 0; endfunction

    function automatic logic [31:0] exp_grant(int d);
        return (m[d].owner >= 0) ? (32'd1 << m[d].owner) : 32'd0;
    endfunction

    task automatic model_step(input int d);
        if (reset) begin
            m[d].owner = -1; m[d].last = N - 1; m[d].cnt = 0;
            m[d].plot = 1'b0; m[d].x = 0; m[d].y = 0; m[d].c = 0;
            mdl_ok = 1'b1;
            return;
        end
        m[d].plot = 1'b0;
        if (m[d].owner < 0) begin
            for (int s = 1; s <= N; s++) begin
                int cnd;
                cnd = (d == 1) ? (m[d].last + s) % N : s - 1;
                if (req[cnd]) begin
                    m[d].owner = cnd;
                    m[d].last  = cnd;
                    break;
                end
            end
        end else begin
            int k;
            bit acc;
            k   = m[d].owner;
            acc = valid[k];
            if (acc) begin
                m[d].cnt++;
                if (!(CLIP && (chx(k) >= 160 || chy(k) >= 120))) begin
                    m[d].plot = 1'b1;
                    m[d].x = chx(k); m[d].y = chy(k); m[d].c = chc(k);
                end
            end
            if (!req[k] || (max_burst(d) > 0 && acc && m[d].cnt >= max_burst(d))) begin
                m[d].owner = -1;
                m[d].cnt   = 0;
            end
        end
    endtask

    task automatic tick();
        bit pre_ok;
        @(negedge clock);
        pre_ok = mdl_ok;
        for (int d = 0; d < 2; d++) begin
            ack_pre[d] = ack_o[d];
            if (pre_ok) chk($sformatf("m%0d_ack", d), 32'(ack_o[d]), exp_grant(d) & 32'(valid));
        end
        @(posedge clock);
        model_step(0);
        model_step(1);
        #1;
        if (mdl_ok) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("m%0d_grant", d), 32'(grant_o[d]), exp_grant(d));
                chk($sformatf("m%0d_busy", d),  32'(busy_o[d]),  32'(m[d].owner >= 0));
                chk($sformatf("m%0d_plot", d),  32'(plot_o[d]),  32'(m[d].plot));
                chk($sformatf("m%0d_x", d),     32'(x_o[d]),     32'(m[d].x));
                chk($sformatf("m%0d_y", d),     32'(y_o[d]),     32'(m[d].y));
                chk($sformatf("m%0d_color", d), 32'(c_o[d]),     32'(m[d].c));
            end
        end
    endtask

    // Target channel gets the given pixel; every other channel gets a distinct decoy.
    task automatic drive_px(input int ch, input int px, input int py, input int pc);
        for (int k = 0; k < N; k++) begin
            x_in[k*XW +: XW]     = (k == ch) ? XW'(px) : XW'(px) ^ XW'(8'h5A + k);
            y_in[k*YW +: YW]     = (k == ch) ? YW'(py) : YW'(py) ^ YW'(7'h2B + k);
            color_in[k*CW +: CW] = (k == ch) ? CW'(pc) : CW'(pc) ^ CW'(3'h5);
        end
    endtask

    typedef struct {
        bit       rst;
        logic [3:0] rq;
        logic [3:0] vl;
        int       ch;
        int       px, py, pc;
        logic [3:0] e_ack;
        logic [3:0] e_grant;
        bit       e_busy;
        bit       e_plot;
        int       ex, ey, ec;
    } vec_t;

    function automatic vec_t mk(bit rst, logic [3:0] rq, logic [3:0] vl, int ch, int px, int py, int pc,
                                logic [3:0] e_ack, logic [3:0] e_grant, bit e_busy, bit e_plot,
                                int ex, int ey, int ec);
        vec_t v;
        v.rst = rst; v.rq = rq; v.vl = vl; v.ch = ch; v.px = px; v.py = py; v.pc = pc;
        v.e_ack = e_ack; v.e_grant = e_grant; v.e_busy = e_busy; v.e_plot = e_plot;
        v.ex = ex; v.ey = ey; v.ec = ec;
        return v;
    endfunction

    vec_t tv [13];

    initial begin
        reset = 1'b1; req = '0; valid = '0; x_in = '0; y_in = '0; color_in = '0;
        tick();
        tick();

        // Fixed-priority instance, cycle by cycle.
        tv[0]  = mk(1, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0000, 4'b0000, 0, 0,   0,   0, 0);
        tv[1]  = mk(0, 4'b1010, 4'b0000, 1,   0,   0, 0, 4'b0000, 4'b0010, 1, 0,   0,   0, 0);
        tv[2]  = mk(0, 4'b1010, 4'b0010, 1,  10,  20, 5, 4'b0010, 4'b0010, 1, 1,  10,  20, 5);
        tv[3]  = mk(0, 4'b1010, 4'b0000, 1,  77,  77, 1, 4'b0000, 4'b0010, 1, 0,  10,  20, 5);
        tv[4]  = mk(0, 4'b1010, 4'b0100, 2,  99,   9, 4, 4'b0000, 4'b0010, 1, 0,  10,  20, 5);
        tv[5]  = mk(0, 4'b1000, 4'b0010, 1,  11,  21, 6, 4'b0010, 4'b0000, 0, 1,  11,  21, 6);
        tv[6]  = mk(0, 4'b1000, 4'b1000, 3,  50,  50, 1, 4'b0000, 4'b1000, 1, 0,  11,  21, 6);
        tv[7]  = mk(0, 4'b1000, 4'b1000, 3, 160,   5, 2, 4'b1000, 4'b1000, 1, !CLIP,
                    CLIP ? 11 : 160, CLIP ? 21 : 5, CLIP ? 6 : 2);
        tv[8]  = mk(0, 4'b1000, 4'b1000, 3, 159, 119, 7, 4'b1000, 4'b1000, 1, 1, 159, 119, 7);
        tv[9]  = mk(0, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0000, 4'b0000, 0, 0, 159, 119, 7);
        tv[10] = mk(0, 4'b0001, 4'b0000, 0,   0,   0, 0, 4'b0000, 4'b0001, 1, 0, 159, 119, 7);
        tv[11] = mk(0, 4'b0001, 4'b0001, 0,   1,   2, 3, 4'b0001, 4'b0001, 1, 1,   1,   2, 3);
        tv[12] = mk(1, 4'b0001, 4'b0001, 0,   4,   4, 4, 4'b0001, 4'b0000, 0, 0,   0,   0, 0);

        for (int i = 0; i < 13; i++) begin
            reset = tv[i].rst; req = tv[i].rq; valid = tv[i].vl;
            drive_px(tv[i].ch, tv[i].px, tv[i].py, tv[i].pc);
            tick();
            chk($sformatf("tv%0d_ack", i),   32'(ack_pre[0]),  32'(tv[i].e_ack));
            chk($sformatf("tv%0d_grant", i), 32'(grant_o[0]),  32'(tv[i].e_grant));
            chk($sformatf("tv%0d_busy", i),  32'(busy_o[0]),   32'(tv[i].e_busy));
            chk($sformatf("tv%0d_plot", i),  32'(plot_o[0]),   32'(tv[i].e_plot));
            chk($sformatf("tv%0d_x", i),     32'(x_o[0]),      32'(tv[i].ex));
            chk($sformatf("tv%0d_y", i),     32'(y_o[0]),      32'(tv[i].ey));
            chk($sformatf("tv%0d_color", i), 32'(c_o[0]),      32'(tv[i].ec));
        end

        // Round-robin with burst 2: owners rotate 0,1,2,3,0 with one idle cycle between owners.
        reset = 1'b1; req = '0; valid = '0;
        tick();
        reset = 1'b0; req = '1; valid = '1;
        for (int k = 0; k < N; k++) begin
            x_in[k*XW +: XW] = XW'(10 + k); y_in[k*YW +: YW] = YW'(40 + k); color_in[k*CW +: CW] = CW'(k);
        end
        for (int e = 1; e <= 15; e++) begin
            int own;
            own = ((e - 1) / 3) % N;
            tick();
            chk($sformatf("rr%0d_grant", e), 32'(grant_o[1]), (e % 3 == 0) ? 32'd0 : (32'd1 << own));
            chk($sformatf("rr%0d_plot", e),  32'(plot_o[1]),  32'(e % 3 != 1));
            if (e % 3 != 1) chk($sformatf("rr%0d_x", e), 32'(x_o[1]), 32'(10 + own));
        end

        // Reset in the middle of channel 2's burst.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) tick();
        chk("rst_pre_grant", 32'(grant_o[1]), 32'b0100);
        reset = 1'b1;
        tick();
        chk("rst_grant", 32'(grant_o[1]), 32'd0);
        chk("rst_busy",  32'(busy_o[1]),  32'd0);
        chk("rst_plot",  32'(plot_o[1]),  32'd0);
        chk("rst_xyc",   {x_o[1], y_o[1], c_o[1]}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_first_grant", 32'(grant_o[1]), 32'b0001);

        // Random traffic against the model.
        for (int t = 0; t < 800; t++) begin
            reset = ($urandom_range(0, 149) == 0);
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 7) == 0) req[k] = ~req[k];
            valid = N'($urandom | $urandom);
            for (int k = 0; k < N; k++) begin
                x_in[k*XW +: XW]     = XW'($urandom_range(0, 255));
                y_in[k*YW +: YW]     = YW'($urandom_range(0, 127));
                color_in[k*CW +: CW] = CW'($urandom_range(0, 7));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
